// File: rtl/bfp_pkg.sv
// Shared types and defaults for the block-floating-point alignment controller.
package bfp_pkg;

    localparam int DEF_EXP_WIDTH   = 4;
    localparam int DEF_LANES       = 4;
    localparam int DEF_ZERO_OFFSET = 9;

    typedef enum logic {
        ST_COLLECT,
        ST_EMIT
    } state_t;

    function automatic logic [DEF_EXP_WIDTH-1:0] lane_slice(
        input logic [DEF_EXP_WIDTH*DEF_LANES-1:0] v,
        input int                                 i
    );
        return v[DEF_EXP_WIDTH*i +: DEF_EXP_WIDTH];
    endfunction

endpackage

// File: rtl/bfp_lane_offset.sv
// Per-lane shift offset: zero sentinel or (block max - exponent).
// Optional clamp to MAX_SHIFT when BFP_ALIGN_SAT_EN is defined.
module bfp_lane_offset #(
    parameter int EXP_WIDTH   = 4,
    parameter int ZERO_OFFSET = 9,
    parameter int MAX_SHIFT   = 7
) (
    input  logic [EXP_WIDTH-1:0] lane_exp,
    input  logic [EXP_WIDTH-1:0] max_exp,
    output logic [EXP_WIDTH-1:0] offset,
    output logic                 is_zero
);

    logic [EXP_WIDTH-1:0] diff;
    logic [EXP_WIDTH-1:0] shift;

    if (ZERO_OFFSET >= (1 << EXP_WIDTH) || MAX_SHIFT >= (1 << EXP_WIDTH)) begin : g_bad_param
        $error("ZERO_OFFSET and MAX_SHIFT must fit in EXP_WIDTH bits");
    end

    // max_exp bounds every exponent in the block, so this never wraps
    assign diff = max_exp - lane_exp;

`ifdef BFP_ALIGN_SAT_EN
    localparam logic [EXP_WIDTH-1:0] SAT = EXP_WIDTH'(MAX_SHIFT);
    assign shift = (diff > SAT) ? SAT : diff;
`else
    assign shift = diff;
`endif

    assign is_zero = (lane_exp == '0);
    assign offset  = is_zero ? EXP_WIDTH'(ZERO_OFFSET) : shift;

endmodule

// File: rtl/bfp_align_ctrl.sv
// Collects a block of exponent beats, then replays them with per-lane offsets.
// Optional offset saturation is enabled by BFP_ALIGN_SAT_EN.
module bfp_align_ctrl
    import bfp_pkg::*;
#(
    parameter int EXP_WIDTH   = DEF_EXP_WIDTH,
    parameter int LANES       = DEF_LANES,
    parameter int BLOCK_BEATS = 4,
    parameter int ZERO_OFFSET = DEF_ZERO_OFFSET,
    parameter int MAX_SHIFT   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_WIDTH*LANES-1:0] in_exp,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_WIDTH*LANES-1:0] out_offset,
    output logic [EXP_WIDTH-1:0]       out_max_exp,
    output logic [LANES-1:0]           out_zero_mask,
    output logic                       out_last
);

    localparam int PW = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam int BW = $clog2(BLOCK_BEATS + 1);

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]              wr_cnt;
    logic [PW-1:0]              rd_cnt;
    logic [BW-1:0]              beats_reg;
    logic [EXP_WIDTH-1:0]       max_reg;
    logic [EXP_WIDTH-1:0]       beat_max;
    logic [EXP_WIDTH*LANES-1:0] beat_buf [BLOCK_BEATS];
    logic [EXP_WIDTH*LANES-1:0] rd_beat;
    logic [EXP_WIDTH*LANES-1:0] off_raw;
    logic [LANES-1:0]           zero_raw;

    logic in_fire;
    logic out_fire;
    logic blk_end;
    logic emit_last;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign blk_end   = in_last | (wr_cnt == PW'(BLOCK_BEATS - 1));
    assign emit_last = (BW'(rd_cnt) == beats_reg - BW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && blk_end) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready && emit_last) state_nxt = ST_COLLECT;
            end
            default: state_nxt = ST_COLLECT;
        endcase
    end

    // Running max including the beat currently on the input
    always_comb begin
        beat_max = max_reg;
        for (int i = 0; i < LANES; i++) begin
            if (in_exp[EXP_WIDTH*i +: EXP_WIDTH] > beat_max)
                beat_max = in_exp[EXP_WIDTH*i +: EXP_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            beats_reg <= '0;
            max_reg   <= '0;
            for (int b = 0; b < BLOCK_BEATS; b++) beat_buf[b] <= '0;
        end else begin
            if (in_fire) begin
                beat_buf[wr_cnt] <= in_exp;
                wr_cnt           <= wr_cnt + PW'(1);
                max_reg          <= beat_max;
                if (blk_end) begin
                    beats_reg <= BW'(wr_cnt) + BW'(1);
                    rd_cnt    <= '0;
                end
            end
            if (out_fire) begin
                rd_cnt <= rd_cnt + PW'(1);
                if (emit_last) begin
                    wr_cnt  <= '0;
                    max_reg <= '0;
                end
            end
        end
    end

    assign rd_beat = beat_buf[rd_cnt];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bfp_lane_offset #(
            .EXP_WIDTH  (EXP_WIDTH),
            .ZERO_OFFSET(ZERO_OFFSET),
            .MAX_SHIFT  (MAX_SHIFT)
        ) u_off (
            .lane_exp(rd_beat[EXP_WIDTH*i +: EXP_WIDTH]),
            .max_exp (max_reg),
            .offset  (off_raw[EXP_WIDTH*i +: EXP_WIDTH]),
            .is_zero (zero_raw[i])
        );
    end

    // Outputs read as zero outside EMIT
    assign out_offset    = out_valid ? off_raw  : '0;
    assign out_max_exp   = out_valid ? max_reg  : '0;
    assign out_zero_mask = out_valid ? zero_raw : '0;
    assign out_last      = out_valid & emit_last;

endmodule

// File: tb/tb_bfp_align_ctrl.sv
// Self-checking bench for bfp_align_ctrl: vector table, hand sequences and
// randomized blocks against a behavioural model.
module tb_bfp_align_ctrl;
    import bfp_pkg::*;

`ifdef BFP_ALIGN_SAT_EN
    localparam int TB_MAX_SHIFT = 5;
`else
    localparam int TB_MAX_SHIFT = 7;
`endif
    localparam int ZO = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_exp = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_offset;
    logic [3:0]  out_max_exp;
    logic [3:0]  out_zero_mask;
    logic        out_last;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bfp_align_ctrl #(
        .EXP_WIDTH  (4),
        .LANES      (4),
        .BLOCK_BEATS(4),
        .ZERO_OFFSET(ZO),
        .MAX_SHIFT  (TB_MAX_SHIFT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_exp       (in_exp),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_offset   (out_offset),
        .out_max_exp  (out_max_exp),
        .out_zero_mask(out_zero_mask),
        .out_last     (out_last)
    );

    typedef struct {
        int          n;
        bit          use_last;
        logic [15:0] beat  [4];
        logic [3:0]  emax;
        logic [15:0] eoff  [4];
        logic [3:0]  emask [4];
    } vec_t;

    vec_t tbl [4];

    function automatic logic [15:0] pack4(int a0, int a1, int a2, int a3);
        return {a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model(input logic [15:0] b [4], input int n,
                         output logic [3:0] mx, output logic [15:0] off [4],
                         output logic [3:0] msk [4]);
        int m;
        int e;
        int d;
        m = 0;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 4; i++) begin
                e = int'(lane_slice(b[k], i));
                if (e > m) m = e;
            end
        mx = m[3:0];
        for (int k = 0; k < 4; k++) begin
            off[k] = '0;
            msk[k] = '0;
        end
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 4; i++) begin
                e = int'(lane_slice(b[k], i));
`ifdef BFP_ALIGN_SAT_EN
                d = (m - e > TB_MAX_SHIFT) ? TB_MAX_SHIFT : m - e;
`else
                d = m - e;
`endif
                if (e == 0) d = ZO;
                off[k][4*i +: 4] = d[3:0];
                msk[k][i] = (e == 0);
            end
    endtask

    task automatic send(input logic [15:0] b [4], input int n,
                        input bit use_last, input bit rnd);
        int guard;
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_exp   = 16'($urandom);
                    in_last  = 1'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_exp   = b[k];
            in_last  = use_last && (k == n - 1);
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("send_timeout", 32'(guard), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("latency_valid", 32'(out_valid), 1);
        check("latency_in_ready", 32'(in_ready), 0);
    endtask

    task automatic recv(input logic [3:0] emax, input logic [15:0] eoff [4],
                        input logic [3:0] emask [4], input int n,
                        input int take, input int stall_at, input bit rnd);
        int k;
        int guard;
        int stall;
        k = 0;
        guard = 0;
        stall = 0;
        while (k < take && guard < 200) begin
            if (out_valid) begin
                check("offset", 32'(out_offset), 32'(eoff[k]));
                check("max_exp", 32'(out_max_exp), 32'(emax));
                check("zero_mask", 32'(out_zero_mask), 32'(emask[k]));
                check("last", 32'(out_last), 32'(k == n - 1));
                check("emit_in_ready", 32'(in_ready), 0);
                if (k == stall_at && stall < 3) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (rnd) begin
                    in_valid = 1'b1;
                    in_exp   = 16'($urandom);
                    in_last  = 1'($urandom);
                end
                if (out_ready) k++;
            end else begin
                check("out_valid_drop", 32'(out_valid), 1);
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("recv_timeout", 32'(guard), 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        if (take == n) begin
            check("done_out_valid", 32'(out_valid), 0);
            check("done_in_ready", 32'(in_ready), 1);
        end
    endtask

    initial begin
        logic [15:0] rb   [4];
        logic [15:0] roff [4];
        logic [3:0]  rmsk [4];
        logic [3:0]  rmax;
        int          rn;
        bit          rl;

        tbl[0].n = 2; tbl[0].use_last = 1'b1;
        tbl[0].beat[0] = pack4(3, 5, 0, 2);
        tbl[0].beat[1] = pack4(7, 1, 4, 7);
        tbl[0].beat[2] = '0; tbl[0].beat[3] = '0;
        tbl[0].emax = 4'd7;
        tbl[0].eoff[0] = pack4(4, 2, 9, 5);
`ifdef BFP_ALIGN_SAT_EN
        tbl[0].eoff[1] = pack4(0, 5, 3, 0);
`else
        tbl[0].eoff[1] = pack4(0, 6, 3, 0);
`endif
        tbl[0].eoff[2] = '0; tbl[0].eoff[3] = '0;
        tbl[0].emask[0] = 4'b0100; tbl[0].emask[1] = 4'b0000;
        tbl[0].emask[2] = '0; tbl[0].emask[3] = '0;

        tbl[1].n = 4; tbl[1].use_last = 1'b0;
        tbl[1].beat[0] = pack4(1, 1, 1, 1);
        tbl[1].beat[1] = pack4(2, 2, 2, 2);
        tbl[1].beat[2] = pack4(3, 3, 3, 3);
        tbl[1].beat[3] = pack4(6, 0, 6, 0);
        tbl[1].emax = 4'd6;
        tbl[1].eoff[0] = pack4(5, 5, 5, 5);
        tbl[1].eoff[1] = pack4(4, 4, 4, 4);
        tbl[1].eoff[2] = pack4(3, 3, 3, 3);
        tbl[1].eoff[3] = pack4(0, 9, 0, 9);
        tbl[1].emask[0] = '0; tbl[1].emask[1] = '0;
        tbl[1].emask[2] = '0; tbl[1].emask[3] = 4'b1010;

        tbl[2].n = 1; tbl[2].use_last = 1'b1;
        tbl[2].beat[0] = pack4(0, 0, 0, 0);
        tbl[2].beat[1] = '0; tbl[2].beat[2] = '0; tbl[2].beat[3] = '0;
        tbl[2].emax = 4'd0;
        tbl[2].eoff[0] = pack4(9, 9, 9, 9);
        tbl[2].eoff[1] = '0; tbl[2].eoff[2] = '0; tbl[2].eoff[3] = '0;
        tbl[2].emask[0] = 4'b1111;
        tbl[2].emask[1] = '0; tbl[2].emask[2] = '0; tbl[2].emask[3] = '0;

        tbl[3].n = 1; tbl[3].use_last = 1'b1;
        tbl[3].beat[0] = pack4(2, 0, 0, 0);
        tbl[3].beat[1] = '0; tbl[3].beat[2] = '0; tbl[3].beat[3] = '0;
        tbl[3].emax = 4'd2;
        tbl[3].eoff[0] = pack4(0, 9, 9, 9);
        tbl[3].eoff[1] = '0; tbl[3].eoff[2] = '0; tbl[3].eoff[3] = '0;
        tbl[3].emask[0] = 4'b1110;
        tbl[3].emask[1] = '0; tbl[3].emask[2] = '0; tbl[3].emask[3] = '0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_offset", 32'(out_offset), 0);
        check("rst_max", 32'(out_max_exp), 0);
        check("rst_mask", 32'(out_zero_mask), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            send(tbl[v].beat, tbl[v].n, tbl[v].use_last, 1'b0);
            recv(tbl[v].emax, tbl[v].eoff, tbl[v].emask,
                 tbl[v].n, tbl[v].n, -1, 1'b0);
        end

        // Backpressure: 3-cycle stall on the second output beat
        send(tbl[1].beat, 4, 1'b0, 1'b0);
        recv(tbl[1].emax, tbl[1].eoff, tbl[1].emask, 4, 4, 1, 1'b0);

        // Reset after the first output beat, then a fresh block
        send(tbl[0].beat, 2, 1'b1, 1'b0);
        recv(tbl[0].emax, tbl[0].eoff, tbl[0].emask, 2, 1, -1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        send(tbl[3].beat, 1, 1'b1, 1'b0);
        recv(tbl[3].emax, tbl[3].eoff, tbl[3].emask, 1, 1, -1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            rn = $urandom_range(1, 4);
            rl = (rn < 4) ? 1'b1 : 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                rb[k] = 16'($urandom);
                if ($urandom_range(0, 3) == 0) rb[k][4*$urandom_range(0, 3) +: 4] = '0;
            end
            model(rb, rn, rmax, roff, rmsk);
            send(rb, rn, rl, 1'b1);
            recv(rmax, roff, rmsk, rn, rn, -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bfp_align_ctrl.md
Name: bfp_align_ctrl

Overview:
Block-floating-point alignment controller for the GEMM/FFT datapath. Collects a block of 4-lane exponent beats, tracks the running block maximum exponent, then replays the buffered beats with per-lane right-shift offsets (max − exp) for the mantissa aligners. Sits between the exponent unpack stage and the mantissa shifter array. Sequences the collect-then-emit phases with valid/ready handshakes on both sides.

Parameters:
EXP_WIDTH, 4, exponent field width; also the offset width.
LANES, 4, exponents per beat.
BLOCK_BEATS, 4, maximum beats per block; the buffer depth.
ZERO_OFFSET, 9, sentinel offset for a zero exponent; must fit in EXP_WIDTH bits.
MAX_SHIFT, 7, saturation limit, used only with BFP_ALIGN_SAT_EN.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  controller accepts a beat
in_exp  in  EXP_WIDTH*LANES  lane i at bits [EXP_WIDTH*i +: EXP_WIDTH]
in_last  in  1  final beat of a short block
out_valid  out  1  offset beat valid
out_ready  in  1  downstream accepts a beat
out_offset  out  EXP_WIDTH*LANES  per-lane shift offset, same lane packing
out_max_exp  out  EXP_WIDTH  block maximum exponent, constant for the whole block
out_zero_mask  out  LANES  bit i set when lane i exponent is 0
out_last  out  1  final beat of the block

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low. All state resets on rst_n low.
- FSM has two states, COLLECT (reset state) and EMIT.
- Reset values: state=COLLECT, wr_cnt=0, rd_cnt=0, max_reg=0, beats_reg=0, out_valid=0, out_last=0, in_ready=1. out_offset, out_max_exp and out_zero_mask are 0 during reset.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - On each beat with in_valid&in_ready: write in_exp to buf[wr_cnt], increment wr_cnt, and set max_reg to max(max_reg, all lanes).
  - Zero-exponent lanes still enter the max compare. A zero never raises the max.
  - The block ends on an accepted beat when in_last=1 or wr_cnt==BLOCK_BEATS−1.
  - At block end: register beats_reg = wr_cnt+1, including the final beat in max_reg; set rd_cnt=0; go to EMIT.
- EMIT:
  - in_ready=0 and out_valid=1.
  - Outputs are driven from buf[rd_cnt] and max_reg.
  - Per lane: offset = (exp==0) ? ZERO_OFFSET : max_reg − exp. No underflow is possible because max_reg ≥ every exponent in the block.
  - out_last=(rd_cnt==beats_reg−1).
  - On out_valid&out_ready: increment rd_cnt. On the last beat: clear wr_cnt and max_reg, then return to COLLECT.
- Latency: the first output beat is valid in the cycle after the final input beat is accepted.
- Throughput: N input beats plus N output beats per block. There is no overlap.
- Backpressure: while out_ready=0, every output holds stable.
- in_valid with in_ready=0 is ignored; upstream must hold the beat.
- An all-zero block gives max=0 and every offset = ZERO_OFFSET.
- rst_n asserted mid-block (either state) discards the block and returns to the reset values.

Optional Feature:
Macro: BFP_ALIGN_SAT_EN.
- Defined: non-zero-lane offsets clamp to min(max_reg − exp, MAX_SHIFT). The ZERO_OFFSET sentinel is never clamped.
- Undefined: offsets are unclamped and MAX_SHIFT is unused.

Decomposition:
- Shared package bfp_pkg holds:
  - FSM state enum: ST_COLLECT, ST_EMIT.
  - Default EXP_WIDTH, LANES and ZERO_OFFSET constants.
  - Lane-slice helper function.
- One sub-module: bfp_lane_offset. It is the per-lane combinational offset computation (zero test, subtract, optional clamp), instantiated LANES times in a generate loop.
- The FSM, counters, buffer and max register stay in the top level.

Test Plan:
- Short block: beat0 {3,5,0,2}, beat1 {7,1,4,7} with in_last. Required: out_max_exp=7; beat0 offsets {4,2,9,5} with mask 0100; beat1 offsets {0,6,3,0} with out_last=1.
- Full block, no in_last: beats {1,1,1,1}, {2,2,2,2}, {3,3,3,3}, {6,0,6,0}. Required: EMIT is entered after the 4th beat; max=6; offsets {5,5,5,5}, {4,4,4,4}, {3,3,3,3}, {0,9,0,9}; out_last on beat 4 only.
- All-zero block: one beat {0,0,0,0} with in_last. Required: max=0, offsets {9,9,9,9}, mask 1111.
- Backpressure: hold out_ready=0 for 3 cycles mid-EMIT. Required: outputs stable, in_ready=0, no beat lost or duplicated.
- BFP_ALIGN_SAT_EN with MAX_SHIFT=5 on the short-block stimulus. Required: beat1 lane1 gives 5, not 6; the zero lane still gives 9.
- Reset mid-EMIT: pulse rst_n low after the first output beat. Required: out_valid=0 and in_ready=1; a following block {2,0,0,0} gives max=2 (no stale max).
